// File: rtl/arb2x1_if.sv
// arb2x1_if: valid/ready bundle for the 2:1 arbiter (two input channels, one output channel)
interface arb2x1_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] A, B, Y;
    logic A_valid, A_ready, B_valid, B_ready, Es, Y_valid, Y_ready;
    modport master (output A, A_valid, B, B_valid, Y_ready, input A_ready, B_ready, Y, Es, Y_valid);
    modport slave (input A, A_valid, B, B_valid, Y_ready, output A_ready, B_ready, Y, Es, Y_valid);
endinterface

// File: rtl/arb2x1.sv
// arb2x1: 2:1 valid/ready arbiter into a one-entry output register; ARB2X1_ROUND_ROBIN_EN selects round-robin, else A has fixed priority
module arb2x1 #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    arb2x1_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] y_q;
    logic es_q, can_load, pick_b, accept, contend_b;
`ifdef ARB2X1_ROUND_ROBIN_EN
    logic last_b;
    // last-grant pointer; starts at B so A wins the first contention
    always_ff @(posedge clk)
        if (!rst_n) last_b <= 1'b1;
        else if (accept) last_b <= bus.B_ready;
    assign contend_b = !last_b;
`else
    assign contend_b = 1'b0;
`endif
    // grant, handshakes and next state; ready is forced low while in reset
    always_comb begin
        can_load = rst_n && (state == EMPTY || bus.Y_ready);
        pick_b = bus.B_valid && (!bus.A_valid || contend_b);
        bus.A_ready = can_load && bus.A_valid && !pick_b;
        bus.B_ready = can_load && pick_b;
        accept = bus.A_ready || bus.B_ready;
        state_nx = accept ? FULL : bus.Y_ready ? EMPTY : state;
    end
    // state register
    always_ff @(posedge clk)
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    // output word and source; held when nothing is accepted
    always_ff @(posedge clk)
        if (!rst_n) begin
            y_q <= '0;
            es_q <= 1'b0;
        end else if (accept) begin
            y_q <= bus.B_ready ? bus.B : bus.A;
            es_q <= bus.B_ready;
        end
    assign bus.Y = y_q;
    assign bus.Es = es_q;
    assign bus.Y_valid = (state == FULL);
endmodule

// File: tb/tb_arb2x1.sv
// tb_arb2x1: directed and random scoreboard bench for arb2x1
module tb_arb2x1;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    arb2x1_if #(.WIDTH(8)) bus();
    arb2x1 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef ARB2X1_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    int checks = 0, errors = 0;
    logic [8:0] q[$];
    logic m_full = 1'b0, m_last_b = 1'b1, m_es = 1'b0;
    logic [7:0] m_y = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model: expected handshakes and register contents, pushes accepted words
    always @(negedge clk) begin : model
        logic cl, pb, ea, eb;
        cl = !m_full || bus.Y_ready;
        pb = bus.B_valid && (!bus.A_valid || (RR && !m_last_b));
        ea = rst_n && cl && bus.A_valid && !pb;
        eb = rst_n && cl && pb;
        chk("A_ready", bus.A_ready, ea);
        chk("B_ready", bus.B_ready, eb);
        chk("Y_valid", bus.Y_valid, m_full);
        chk("Y", bus.Y, m_y);
        chk("Es", bus.Es, m_es);
        if (!rst_n) begin
            m_full = 1'b0; m_y = 8'h00; m_es = 1'b0; m_last_b = 1'b1;
            q.delete();
        end else if (ea || eb) begin
            m_full = 1'b1; m_es = eb; m_y = eb ? bus.B : bus.A; m_last_b = eb;
            q.push_back({m_es, m_y});
        end else if (m_full && bus.Y_ready) m_full = 1'b0;
    end

    // monitor: every consumed output word must match the scoreboard front
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n && bus.Y_valid && bus.Y_ready) begin
            if (q.size() == 0) chk("sb_unexpected_word", {bus.Es, bus.Y}, 9'h1ff);
            else begin
                e = q.pop_front();
                chk("sb_word", {bus.Es, bus.Y}, e);
            end
        end
    end

    initial begin
        bus.A = 8'h00; bus.B = 8'h00; bus.A_valid = 1'b0; bus.B_valid = 1'b0; bus.Y_ready = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_Y_valid", bus.Y_valid, 0);
        chk("rst_Y", bus.Y, 0);
        chk("rst_Es", bus.Es, 0);
        step();
        rst_n = 1'b1; bus.A = 8'h3C; bus.A_valid = 1'b1; bus.Y_ready = 1'b1;
        @(negedge clk);
        chk("single_A_ready", bus.A_ready, 1);
        step();
        bus.A_valid = 1'b0;
        @(negedge clk);
        chk("single_Y", bus.Y, 8'h3C);
        chk("single_Es", bus.Es, 0);
        chk("single_Y_valid", bus.Y_valid, 1);
        step();
        @(negedge clk);
        chk("pulse_Y_valid_low", bus.Y_valid, 0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.A = 8'h11; bus.B = 8'h22; bus.A_valid = 1'b1; bus.B_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("contend_Y", bus.Y, (RR && i % 2 == 1) ? 8'h22 : 8'h11);
            chk("contend_Es", bus.Es, RR && i % 2 == 1);
            if (!RR) chk("fixed_B_ready", bus.B_ready, 0);
        end
        step();
        bus.A_valid = 1'b0; bus.B_valid = 1'b0;
        repeat (2) step();
        bus.A = 8'hAA; bus.A_valid = 1'b1; bus.Y_ready = 1'b0;
        step();
        bus.A = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_A_ready", bus.A_ready, 0);
            chk("stall_Y", bus.Y, 8'hAA);
            chk("stall_Es", bus.Es, 0);
            step();
        end
        bus.Y_ready = 1'b1;
        @(negedge clk);
        chk("unstall_A_ready", bus.A_ready, 1);
        step();
        bus.A_valid = 1'b0;
        @(negedge clk);
        chk("unstall_Y", bus.Y, 8'h55);
        step();
        bus.A = 8'h77; bus.A_valid = 1'b1;
        step();
        bus.A_valid = 1'b0; bus.Y_ready = 1'b0;
        step();
        rst_n = 1'b0; bus.A_valid = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_Y_valid", bus.Y_valid, 0);
        chk("midrst_Y", bus.Y, 0);
        chk("midrst_Es", bus.Es, 0);
        chk("midrst_A_ready", bus.A_ready, 0);
        step();
        rst_n = 1'b1; bus.A = 8'h01; bus.B = 8'h02; bus.A_valid = 1'b1; bus.B_valid = 1'b1; bus.Y_ready = 1'b1;
        @(negedge clk);
        chk("postrst_A_ready", bus.A_ready, 1);
        chk("postrst_B_ready", bus.B_ready, 0);
        step();
        bus.A_valid = 1'b0; bus.B_valid = 1'b0;
        @(negedge clk);
        chk("postrst_Y", bus.Y, 8'h01);
        for (int i = 0; i < 1000; i++) begin
            step();
            bus.A_valid = 1'($urandom_range(0, 1));
            bus.B_valid = 1'($urandom_range(0, 1));
            bus.Y_ready = 1'($urandom_range(0, 1));
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
        end
        step();
        bus.A_valid = 1'b0; bus.B_valid = 1'b0; bus.Y_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("drain_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
